bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream `bus_if` slave among `N_MASTERS` upstream requesters, such as the core data port and the accelerator DMA, both reaching the same peripheral/memory region. It grants at most one transfer per cycle. It tracks outstanding transactions in an in-order ID FIFO and routes each downstream response (`rvalid`/`rdata`/`err`) back to the master that issued it. It sits between the requesters and the peripheral bus segment.

---
 rtl/bus_arb_pkg.sv | 14 +
 rtl/bus_if.sv | 14 +
 rtl/resp_id_fifo.sv | 60 ++++++
 rtl/bus_rr_arbiter.sv | 96 +++++++++
 tb/tb_bus_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_pkg.sv
// Shared widths and sizing helpers for the round-robin bus arbiter.
package bus_arb_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // Index width; kept at least 1 bit so single-entry structures still have a pointer.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/bus_if.sv
// Request/grant bus with in-order rvalid responses (one response per accepted request).
interface bus_if;
   logic                           req;
   logic                           we;
   logic [bus_arb_pkg::ADDR_W-1:0] addr;
   logic [bus_arb_pkg::DATA_W-1:0] wdata;
   logic                           gnt;
   logic                           rvalid;
   logic [bus_arb_pkg::DATA_W-1:0] rdata;
   logic                           err;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/resp_id_fifo.sv
// In-order FIFO of issuing-master IDs; head is read combinationally for zero-latency response routing.
module resp_id_fifo
   import bus_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int PW = idx_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while the count says they are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream bus among N masters, routing in-order responses
// back to their issuers through an ID FIFO.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_MASTERS       = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   bus_if.slave  mst [N_MASTERS],
   bus_if.master slv,
   output logic  busy_o,
   output logic  protocol_err_o
);
   localparam int IW = idx_width(N_MASTERS);

   logic [N_MASTERS-1:0] req_v;
   logic [N_MASTERS-1:0] we_v;
   logic [ADDR_W-1:0]    addr_v  [N_MASTERS];
   logic [DATA_W-1:0]    wdata_v [N_MASTERS];

   logic [IW-1:0] last_q, last_d;
   logic          perr_q, perr_d;
   logic [IW-1:0] sel;
   logic [IW-1:0] head;
   logic          any_req, slv_req, accept, pop, full, empty;
   int            cand;

   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_mst
         logic hit;
         assign req_v[gi]      = mst[gi].req;
         assign we_v[gi]       = mst[gi].we;
         assign addr_v[gi]     = mst[gi].addr;
         assign wdata_v[gi]    = mst[gi].wdata;
         assign hit            = pop & (head == IW'(gi));
         assign mst[gi].gnt    = accept & (sel == IW'(gi));
         assign mst[gi].rvalid = hit;
         assign mst[gi].rdata  = hit ? slv.rdata : '0;
         assign mst[gi].err    = hit & slv.err;
      end
   endgenerate

   // Scan from furthest to nearest so the nearest requester after last_q wins.
   always_comb begin
      sel  = '0;
      cand = 0;
      for (int k = N_MASTERS; k >= 1; k--) begin
         cand = (int'(last_q) + k) % N_MASTERS;
         if (req_v[IW'(cand)]) sel = IW'(cand);
      end
   end

   assign any_req   = |req_v;
   assign slv_req   = any_req & ~full;
   assign accept    = slv_req & slv.gnt;
   assign pop       = slv.rvalid & ~empty;
   assign slv.req   = slv_req;
   assign slv.we    = we_v[sel];
   assign slv.addr  = addr_v[sel];
   assign slv.wdata = wdata_v[sel];

   resp_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (IW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .data_i  (sel),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

   always_comb begin
      last_d = accept ? sel : last_q;
      perr_d = perr_q | (slv.rvalid & empty);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= IW'(N_MASTERS - 1);
         perr_q <= 1'b0;
      end else begin
         last_q <= last_d;
         perr_q <= perr_d;
      end
   end

   assign busy_o         = ~empty;
   assign protocol_err_o = perr_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_bus_rr_arbiter;
   localparam int N    = 2;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        m_req [N];
   logic        m_we [N];
   logic [31:0] m_addr [N];
   logic [31:0] m_wdata [N];
   logic        m_gnt [N];
   logic        m_rvalid [N];
   logic [31:0] m_rdata [N];
   logic        m_err [N];
   logic        s_gnt, s_rvalid, s_err;
   logic [31:0] s_rdata;
   logic        busy, perr;

   bus_if mst_if [N] ();
   bus_if slv_if ();

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_m
         assign mst_if[gi].req   = m_req[gi];
         assign mst_if[gi].we    = m_we[gi];
         assign mst_if[gi].addr  = m_addr[gi];
         assign mst_if[gi].wdata = m_wdata[gi];
         assign m_gnt[gi]        = mst_if[gi].gnt;
         assign m_rvalid[gi]     = mst_if[gi].rvalid;
         assign m_rdata[gi]      = mst_if[gi].rdata;
         assign m_err[gi]        = mst_if[gi].err;
      end
   endgenerate
   assign slv_if.gnt    = s_gnt;
   assign slv_if.rvalid = s_rvalid;
   assign slv_if.rdata  = s_rdata;
   assign slv_if.err    = s_err;

   bus_rr_arbiter #(.N_MASTERS(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mst            (mst_if),
      .slv            (slv_if),
      .busy_o         (busy),
      .protocol_err_o (perr)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: outstanding issuer IDs in order, last granted master, sticky error.
   int exp_q[$];
   int last_m;
   bit perr_m;
   bit granted [N];
   logic        obs_gnt [N];
   logic        obs_rvalid [N];
   logic [31:0] obs_rdata [N];
   logic        obs_err [N];
   logic        obs_slv_req, obs_perr, obs_busy;

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         m_req[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
      end
      s_gnt = 0; s_rvalid = 0; s_rdata = 0; s_err = 0;
   endtask

   task automatic step(input string tag);
      int  sel, head, c, mux;
      bit  any, full, acc, pop;
      #1;
      sel = 0; any = 0;
      for (int k = 1; k <= N; k++) begin
         c = (last_m + k) % N;
         if (!any && m_req[c]) begin sel = c; any = 1; end
      end
      full = (exp_q.size() >= MAXO);
      acc  = any && !full && s_gnt;
      pop  = s_rvalid && (exp_q.size() > 0);
      head = pop ? exp_q[0] : -1;
      mux  = any ? sel : 0;

      obs_slv_req = slv_if.req;
      obs_perr    = perr;
      obs_busy    = busy;
      check_val({tag, ".slv_req"}, {31'b0, slv_if.req}, {31'b0, any && !full});
      check_val({tag, ".slv_we"}, {31'b0, slv_if.we}, {31'b0, m_we[mux]});
      check_val({tag, ".slv_addr"}, slv_if.addr, m_addr[mux]);
      check_val({tag, ".slv_wdata"}, slv_if.wdata, m_wdata[mux]);
      for (int i = 0; i < N; i++) begin
         obs_gnt[i] = m_gnt[i]; obs_rvalid[i] = m_rvalid[i];
         obs_rdata[i] = m_rdata[i]; obs_err[i] = m_err[i];
         check_val($sformatf("%s.gnt%0d", tag, i), {31'b0, m_gnt[i]}, {31'b0, acc && sel == i});
         check_val($sformatf("%s.rvalid%0d", tag, i), {31'b0, m_rvalid[i]}, {31'b0, head == i});
         check_val($sformatf("%s.rdata%0d", tag, i), m_rdata[i], (head == i) ? s_rdata : 32'h0);
         check_val($sformatf("%s.err%0d", tag, i), {31'b0, m_err[i]}, {31'b0, (head == i) && s_err});
         granted[i] = acc && sel == i;
      end
      check_val({tag, ".busy"}, {31'b0, busy}, {31'b0, exp_q.size() != 0});
      check_val({tag, ".perr"}, {31'b0, perr}, {31'b0, perr_m});

      if (s_rvalid && !pop) begin
         perr_m = 1;
         $display("%s spurious rvalid dropped", tag);
      end
      if (pop) begin
         $display("%s RSP m%0d rdata=%h err=%0d", tag, head, s_rdata, s_err);
         void'(exp_q.pop_front());
      end
      if (acc) begin
         $display("%s ACC m%0d we=%0d addr=%h", tag, sel, m_we[sel], m_addr[sel]);
         exp_q.push_back(sel);
         last_m = sel;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 0;
      clear_inputs();
      #1;
      check_val({tag, ".rst_busy"}, {31'b0, busy}, 32'h0);
      check_val({tag, ".rst_perr"}, {31'b0, perr}, 32'h0);
      check_val({tag, ".rst_slv_req"}, {31'b0, slv_if.req}, 32'h0);
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("%s.rst_gnt%0d", tag, i), {31'b0, m_gnt[i]}, 32'h0);
         check_val($sformatf("%s.rst_rvalid%0d", tag, i), {31'b0, m_rvalid[i]}, 32'h0);
      end
      exp_q.delete();
      last_m = N - 1;
      perr_m = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      clear_inputs();
      do_reset("init");

      // Single requester with a 1-cycle slave.
      m_req[1] = 1; m_addr[1] = 32'h10; s_gnt = 1;
      step("single.req");
      check_val("single.gnt1", {31'b0, obs_gnt[1]}, 32'h1);
      m_req[1] = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
      step("single.rsp");
      check_val("single.rvalid1", {31'b0, obs_rvalid[1]}, 32'h1);
      check_val("single.rdata1", obs_rdata[1], 32'hDEADBEEF);
      check_val("single.rvalid0", {31'b0, obs_rvalid[0]}, 32'h0);

      // Both masters requesting continuously: strict alternation.
      do_reset("alt");
      for (int c = 0; c < 6; c++) begin
         m_req[0] = 1; m_req[1] = 1; m_addr[0] = 32'h100 + c; m_addr[1] = 32'h200 + c;
         s_gnt = 1; s_rvalid = (c > 0); s_rdata = 32'hA000 + c;
         step($sformatf("alt%0d", c));
         check_val($sformatf("alt%0d.order", c), {31'b0, obs_gnt[c % 2]}, 32'h1);
         if (c > 0) check_val($sformatf("alt%0d.route", c), {31'b0, obs_rvalid[(c - 1) % 2]}, 32'h1);
      end

      // Slow slave: FIFO fills and stalls until the first response.
      do_reset("full");
      m_req[0] = 1; m_req[1] = 1; s_gnt = 1; s_rvalid = 0;
      for (int c = 0; c < 5; c++) begin
         step($sformatf("full%0d", c));
         if (c >= 2) begin
            check_val($sformatf("full%0d.stall_req", c), {31'b0, obs_slv_req}, 32'h0);
            check_val($sformatf("full%0d.stall_gnt0", c), {31'b0, obs_gnt[0]}, 32'h0);
         end
      end
      s_rvalid = 1; s_rdata = 32'h1234;
      step("full.pop");
      check_val("full.pop_rvalid0", {31'b0, obs_rvalid[0]}, 32'h1);
      check_val("full.pop_stall", {31'b0, obs_slv_req}, 32'h0);
      s_rvalid = 0;
      step("full.resume");
      check_val("full.resume_gnt0", {31'b0, obs_gnt[0]}, 32'h1);

      // Error response on a write.
      do_reset("err");
      m_req[0] = 1; m_we[0] = 1; m_addr[0] = 32'h20; m_wdata[0] = 32'h55; s_gnt = 1;
      step("err.wr");
      m_req[0] = 0; s_rvalid = 1; s_err = 1;
      step("err.rsp");
      check_val("err.err0", {31'b0, obs_err[0]}, 32'h1);
      check_val("err.err1", {31'b0, obs_err[1]}, 32'h0);
      check_val("err.rvalid0", {31'b0, obs_rvalid[0]}, 32'h1);

      // Random traffic; held requests keep their payload until granted.
      do_reset("rnd");
      for (int i = 0; i < N; i++) granted[i] = 0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(m_req[i] && !granted[i])) begin
               m_req[i]   = ($urandom_range(0, 2) != 0);
               m_we[i]    = $urandom_range(0, 1);
               m_addr[i]  = $urandom;
               m_wdata[i] = $urandom;
            end
         end
         s_gnt    = ($urandom_range(0, 3) != 0);
         s_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
         s_rdata  = $urandom;
         s_err    = ($urandom_range(0, 7) == 0);
         step($sformatf("rnd%0d", c));
      end

      // Spurious response with an empty FIFO.
      do_reset("spur");
      s_rvalid = 1; s_rdata = 32'hABC;
      step("spur.rsp");
      check_val("spur.rvalid0", {31'b0, obs_rvalid[0]}, 32'h0);
      check_val("spur.rvalid1", {31'b0, obs_rvalid[1]}, 32'h0);
      s_rvalid = 0;
      step("spur.flag");
      check_val("spur.perr", {31'b0, obs_perr}, 32'h1);
      step("spur.sticky");
      check_val("spur.perr_sticky", {31'b0, obs_perr}, 32'h1);

      // Reset with two transactions outstanding.
      do_reset("mid");
      m_req[0] = 1; m_req[1] = 1; s_gnt = 1;
      step("mid.a");
      step("mid.b");
      check_val("mid.busy", {31'b0, obs_busy}, 32'h1);
      do_reset("mid.rst");
      m_req[0] = 1; m_req[1] = 1; s_gnt = 1;
      step("mid.after");
      check_val("mid.after_gnt0", {31'b0, obs_gnt[0]}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
